sprite_render: RTL and testbench

Pixel-generation stage that sits directly downstream of the horizontal and vertical timing counters. It consumes the signed counter values and blank flags, and decides per pixel whether the single bouncing sprite covers the beam. It holds a 12x12 one-bit bitmap (double-buffered, serially loaded) and a sprite position that advances once per frame and reflects off the screen edges. Its output `pixel_on` feeds the RGB output stage.

---
 rtl/sprite_render_if.sv | 29 ++
 rtl/sprite_render.sv | 149 ++++++++++++++
 tb/tb_sprite_render.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_render_if.sv
// Beam/bitmap interface of the sprite renderer.
// master: timing generator / loader side (drives counters, blanks, frame_tick, load stream).
// slave : sprite_render (returns pixel_on, sprite position and load_full).
interface sprite_render_if #(
    parameter int H_CNT_W = 11,
    parameter int V_CNT_W = 11
);
    logic signed [H_CNT_W-1:0] hcounter;
    logic signed [V_CNT_W-1:0] vcounter;
    logic                      hblank;
    logic                      vblank;
    logic                      frame_tick;
    logic                      load_en;
    logic                      load_data;
    logic                      pixel_on;
    logic        [H_CNT_W-2:0] sprite_x;
    logic        [V_CNT_W-2:0] sprite_y;
    logic                      load_full;

    modport master (
        output hcounter, vcounter, hblank, vblank, frame_tick, load_en, load_data,
        input  pixel_on, sprite_x, sprite_y, load_full
    );

    modport slave (
        input  hcounter, vcounter, hblank, vblank, frame_tick, load_en, load_data,
        output pixel_on, sprite_x, sprite_y, load_full
    );
endinterface

// File: rtl/sprite_render.sv
// Bouncing-sprite pixel generator.
// Ports: clk (pixel clock), reset_n (async active-low), bus (sprite_render_if.slave):
//   inputs  hcounter/vcounter (signed beam position), hblank/vblank, frame_tick,
//           load_en/load_data (serial bitmap, MSB-first, row-major)
//   outputs pixel_on (1-cycle latency), sprite_x/sprite_y, load_full.
// A 12x12 bitmap is double-buffered: bits shift into a shadow register and are
// committed to the displayed copy on frame_tick once a full image has arrived.
module sprite_render #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int H_CNT_W     = 11,
    parameter int V_CNT_W     = 11,
    parameter int SPRITE_SIZE = 12,
    parameter int SCALE_LOG2  = 2,
    parameter int SPEED       = 2,
    parameter int X_INIT      = 100,
    parameter int Y_INIT      = 60,
    parameter logic [SPRITE_SIZE*SPRITE_SIZE-1:0] BITMAP_INIT = '1
) (
    input logic              clk,
    input logic              reset_n,
    sprite_render_if.slave   bus
);
    localparam int SPRITE_PX = SPRITE_SIZE << SCALE_LOG2;
    localparam int NBITS     = SPRITE_SIZE * SPRITE_SIZE;
    localparam int MAX_X     = H_RES - SPRITE_PX;
    localparam int MAX_Y     = V_RES - SPRITE_PX;
    localparam int CNT_W     = $clog2(NBITS + 1);
    localparam int IDX_W     = $clog2(NBITS);
    localparam int XW        = H_CNT_W - 1;
    localparam int YW        = V_CNT_W - 1;

    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic             r_dx;     // 0 = moving +, 1 = moving -
    logic             r_dy;
    logic [NBITS-1:0] r_active;
    logic [NBITS-1:0] r_shadow;
    logic [CNT_W-1:0] r_count;
    logic             r_pix;

    // Beam offset relative to sprite origin, one bit wider so a negative result is visible.
    logic [H_CNT_W:0] w_dh;
    logic [V_CNT_W:0] w_dv;
    logic             w_in;
    logic [IDX_W-1:0] w_col;
    logic [IDX_W-1:0] w_row;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_ridx;
    logic             w_bit;

    assign w_dh = {bus.hcounter[H_CNT_W-1], bus.hcounter} - {2'b00, r_x};
    assign w_dv = {bus.vcounter[V_CNT_W-1], bus.vcounter} - {2'b00, r_y};
    assign w_in = !bus.hcounter[H_CNT_W-1] && !bus.vcounter[V_CNT_W-1]
                  && !w_dh[H_CNT_W] && (w_dh[H_CNT_W-1:0] < H_CNT_W'(SPRITE_PX))
                  && !w_dv[V_CNT_W] && (w_dv[V_CNT_W-1:0] < V_CNT_W'(SPRITE_PX));
    assign w_col  = w_dh[SCALE_LOG2 +: IDX_W];
    assign w_row  = w_dv[SCALE_LOG2 +: IDX_W];
    assign w_idx  = w_row * IDX_W'(SPRITE_SIZE) + w_col;
    // Row 0 col 0 was shifted in first, so it sits at the MSB.
    assign w_ridx = IDX_W'(NBITS - 1) - w_idx;
    assign w_bit  = w_in ? r_active[w_ridx] : 1'b0;

    // Next position: sums are one bit wider than the position so nothing wraps.
    logic [XW:0]   w_x_up;
    logic [YW:0]   w_y_up;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic          w_dx_nxt;
    logic          w_dy_nxt;

    assign w_x_up = {1'b0, r_x} + (XW + 1)'(SPEED);
    assign w_y_up = {1'b0, r_y} + (YW + 1)'(SPEED);

    always_comb begin
        w_x_nxt  = r_x;
        w_dx_nxt = r_dx;
        if (!r_dx) begin
            if (w_x_up > (XW + 1)'(MAX_X)) begin
                w_x_nxt  = XW'(MAX_X);
                w_dx_nxt = 1'b1;
            end else begin
                w_x_nxt = w_x_up[XW-1:0];
            end
        end else if (r_x < XW'(SPEED)) begin
            w_x_nxt  = '0;
            w_dx_nxt = 1'b0;
        end else begin
            w_x_nxt = r_x - XW'(SPEED);
        end
    end

    always_comb begin
        w_y_nxt  = r_y;
        w_dy_nxt = r_dy;
        if (!r_dy) begin
            if (w_y_up > (YW + 1)'(MAX_Y)) begin
                w_y_nxt  = YW'(MAX_Y);
                w_dy_nxt = 1'b1;
            end else begin
                w_y_nxt = w_y_up[YW-1:0];
            end
        end else if (r_y < YW'(SPEED)) begin
            w_y_nxt  = '0;
            w_dy_nxt = 1'b0;
        end else begin
            w_y_nxt = r_y - YW'(SPEED);
        end
    end

    logic w_full;
    assign w_full = (r_count == CNT_W'(NBITS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x      <= XW'(X_INIT);
            r_y      <= YW'(Y_INIT);
            r_dx     <= 1'b0;
            r_dy     <= 1'b0;
            r_active <= BITMAP_INIT;
            r_shadow <= '0;
            r_count  <= '0;
            r_pix    <= 1'b0;
        end else begin
            r_pix <= w_bit && !bus.hblank && !bus.vblank;
            if (bus.frame_tick) begin
                r_x  <= w_x_nxt;
                r_y  <= w_y_nxt;
                r_dx <= w_dx_nxt;
                r_dy <= w_dy_nxt;
            end
            // A bit arriving on the commit cycle becomes bit 1 of the next image.
            if (bus.frame_tick && w_full) begin
                r_active <= r_shadow;
                r_count  <= bus.load_en ? CNT_W'(1) : '0;
            end else if (bus.load_en && !w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (bus.load_en) begin
                r_shadow <= {r_shadow[NBITS-2:0], bus.load_data};
            end
        end
    end

    assign bus.pixel_on  = r_pix;
    assign bus.sprite_x  = r_x;
    assign bus.sprite_y  = r_y;
    assign bus.load_full = w_full;
endmodule

// File: tb/tb_sprite_render.sv
module tb_sprite_render;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_render_if #(.H_CNT_W(11), .V_CNT_W(11)) b ();
    sprite_render_if #(.H_CNT_W(11), .V_CNT_W(11)) b2 ();

    sprite_render dut (.clk(clk), .reset_n(rst_n), .bus(b));
    // Odd right limit (641-48=593) so x reaches 1 while moving -; y starts near its limit.
    sprite_render #(.H_RES(641), .X_INIT(591), .Y_INIT(429)) dut2 (
        .clk(clk), .reset_n(rst_n), .bus(b2));

    int checks = 0;
    int errors = 0;

    // Reference model (main DUT)
    bit bm[144];   // displayed image, index row*12+col
    bit shq[$];    // shadow contents, oldest bit first
    int cnt;
    int mx, my, mdx, mdy;

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void step_axis(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + 2 > lim) begin p = lim; d = -1; end
            else p = p + 2;
        end else begin
            if (p < 2) begin p = 0; d = 1; end
            else p = p - 2;
        end
    endfunction

    task automatic model_reset();
        foreach (bm[i]) bm[i] = 1'b1;
        shq.delete();
        for (int i = 0; i < 144; i++) shq.push_back(1'b0);
        cnt = 0; mx = 100; my = 60; mdx = 1; mdy = 1;
    endtask

    function automatic bit exp_pix(int h, int v, bit hb, bit vb);
        if (hb || vb || h < 0 || v < 0) return 1'b0;
        if (h < mx || h >= mx + 48 || v < my || v >= my + 48) return 1'b0;
        return bm[((v - my) / 4) * 12 + (h - mx) / 4];
    endfunction

    int ones;

    // One clock: apply inputs, let the edge happen, check every output against the model.
    task automatic cyc(int h, int v, bit hb, bit vb, bit ft, bit le, bit ld);
        bit e;
        b.hcounter = 11'(h); b.vcounter = 11'(v);
        b.hblank = hb; b.vblank = vb;
        b.frame_tick = ft; b.load_en = le; b.load_data = ld;
        e = exp_pix(h, v, hb, vb);
        @(posedge clk); #1;
        if (ft && cnt == 144) begin
            for (int i = 0; i < 144; i++) bm[i] = shq[i];
            cnt = 0;
        end
        if (le) begin
            shq.push_back(ld); void'(shq.pop_front());
            if (cnt < 144) cnt++;
        end
        if (ft) begin
            step_axis(mx, mdx, 592);
            step_axis(my, mdy, 432);
        end
        chk("pixel_on", int'(b.pixel_on), int'(e));
        chk("sprite_x", int'(b.sprite_x), mx);
        chk("sprite_y", int'(b.sprite_y), my);
        chk("load_full", int'(b.load_full), int'(cnt == 144));
        if (b.pixel_on) ones++;
    endtask

    task automatic idle_tick(bit ft);
        cyc(-1, -1, 1'b1, 1'b1, ft, 1'b0, 1'b0);
    endtask

    task automatic load_bit(bit d);
        cyc(-1, -1, 1'b1, 1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic sweep_sprite();
        int x0, y0;
        x0 = mx; y0 = my;
        ones = 0;
        for (int v = y0 - 4; v < y0 + 52; v++)
            for (int h = x0 - 8; h < x0 + 56; h++)
                cyc(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int x2, y2, dx2, dy2;

    initial begin
        b.hcounter = -11'sd1; b.vcounter = -11'sd1; b.hblank = 1; b.vblank = 1;
        b.frame_tick = 0; b.load_en = 0; b.load_data = 0;
        b2.hcounter = -11'sd1; b2.vcounter = -11'sd1; b2.hblank = 1; b2.vblank = 1;
        b2.frame_tick = 0; b2.load_en = 0; b2.load_data = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_pixel_on", int'(b.pixel_on), 0);
        chk("rst_x", int'(b.sprite_x), 100);
        chk("rst_y", int'(b.sprite_y), 60);
        chk("rst_load_full", int'(b.load_full), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Window sweep containing the whole sprite plus blanking on both axes.
        ones = 0;
        for (int v = -5; v < 130; v++)
            for (int h = -20; h < 200; h++)
                cyc(h, v, h < 0, v < 0, 1'b0, 1'b0, 1'b0);
        chk("init_ones", ones, 2304);

        // Single set bit at row 0 col 0.
        for (int i = 0; i < 144; i++) load_bit(i == 0);
        chk("full_before_tick", int'(b.load_full), 1);
        idle_tick(1'b1);
        chk("full_after_tick", int'(b.load_full), 0);
        sweep_sprite();
        chk("single_ones", ones, 16);

        // 100 bits then tick: no commit, image unchanged.
        for (int i = 0; i < 100; i++) load_bit(1'($urandom));
        idle_tick(1'b1);
        sweep_sprite();
        chk("no_commit_ones", ones, 16);
        for (int i = 0; i < 44; i++) load_bit(1'($urandom));
        idle_tick(1'b1);
        sweep_sprite();

        // Commit with a simultaneous load bit that starts the next image.
        for (int i = 0; i < 144; i++) load_bit(1'($urandom));
        cyc(-1, -1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        sweep_sprite();
        for (int i = 0; i < 142; i++) load_bit(1'($urandom));
        chk("not_full_at_143", int'(b.load_full), 0);
        load_bit(1'b0);
        idle_tick(1'b1);
        sweep_sprite();

        // Reset in the middle of a load.
        for (int i = 0; i < 50; i++) load_bit(1'($urandom));
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("midrst_x", int'(b.sprite_x), 100);
        chk("midrst_full", int'(b.load_full), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_sprite();
        chk("midrst_ones", ones, 2304);
        for (int i = 0; i < 143; i++) load_bit(1'b1);
        chk("midrst_partial_dropped", int'(b.load_full), 0);

        // Random images and random beam probes.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 160; i++) begin
                if ($urandom_range(3) == 0) idle_tick(1'b0);
                load_bit(1'($urandom));
            end
            idle_tick(1'b1);
            for (int i = 0; i < 1500; i++)
                cyc(mx - 10 + int'($urandom_range(69)), my - 10 + int'($urandom_range(69)),
                    $urandom_range(7) == 0, $urandom_range(7) == 0, 1'b0, 1'b0, 1'b0);
        end

        // Edge reflection on the second instance.
        x2 = 591; y2 = 429; dx2 = 1; dy2 = 1;
        for (int t = 0; t < 700; t++) begin
            b2.frame_tick = 1'b1;
            @(posedge clk); #1;
            b2.frame_tick = 1'b0;
            step_axis(x2, dx2, 593);
            step_axis(y2, dy2, 432);
            chk("edge_x", int'(b2.sprite_x), x2);
            chk("edge_y", int'(b2.sprite_y), y2);
            @(posedge clk); #1;
            chk("edge_hold_x", int'(b2.sprite_x), x2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
